fp_addsub_param: RTL and testbench

//  Parametrised IEEE-754-style floating-point add/subtract unit, the successor to the

---
 rtl/fp_addsub_param.sv | 219 +++++++++++++++++++++
 tb/tb_fp_addsub_param.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_param.sv
// Parametrised floating-point add/subtract, one operation per 5 cycles through
// ALIGN/ADD/NORM/ROUND, round-to-nearest-even with Inf/NaN/flush-to-zero handling.
module fp_addsub_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   op_sub,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [3:0]             flags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 4;      // {hidden, man, G, R, S}
    localparam int SW = MAN_W + 5;      // plus carry
    localparam int XW = EXP_W + 2;      // signed exponent arithmetic
    localparam int KW = MAN_W + 2;      // rounding carry + hidden + man
    localparam int LW = $clog2(MW);

    localparam logic [W-1:0]         QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] XONE = XW'(1);

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND} state_t;

    state_t                 r_state;
    logic [W-1:0]           r_a, r_b;
    logic                   r_spec;
    logic [W-1:0]           r_spec_res;
    logic [3:0]             r_spec_flg;
    logic                   r_sign, r_sub;
    logic signed [XW-1:0]   r_exp;
    logic [MW-1:0]          r_mx, r_my, r_nman;
    logic [SW-1:0]          r_sum;

    // ---------------- ALIGN: classify, order by magnitude, shift smaller operand
    logic [EXP_W-1:0] w_ea, w_eb, w_ex, w_ey;
    logic [MAN_W-1:0] w_ma, w_mb, w_xm, w_ym;
    logic             w_sa, w_sb, w_xs;
    logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_y_zero;
    logic [W-2:0]     w_mag_a, w_mag_b;
    logic             w_swap;
    logic [31:0]      w_d, w_sh;
    logic [MW-1:0]    w_yfull, w_ysh, w_my;
    logic             w_ystk;
    logic             w_spec;
    logic [W-1:0]     w_spec_res;
    logic [3:0]       w_spec_flg;

    always_comb begin
        w_sa     = r_a[W-1];
        w_sb     = r_b[W-1];
        w_ea     = r_a[W-2:MAN_W];
        w_eb     = r_b[W-2:MAN_W];
        w_ma     = r_a[MAN_W-1:0];
        w_mb     = r_b[MAN_W-1:0];
        w_a_zero = (w_ea == '0);
        w_b_zero = (w_eb == '0);
        w_a_inf  = (w_ea == '1) && (w_ma == '0);
        w_b_inf  = (w_eb == '1) && (w_mb == '0);
        w_a_nan  = (w_ea == '1) && (w_ma != '0);
        w_b_nan  = (w_eb == '1) && (w_mb != '0);
        w_mag_a  = w_a_zero ? '0 : r_a[W-2:0];
        w_mag_b  = w_b_zero ? '0 : r_b[W-2:0];
        w_swap   = (w_mag_b > w_mag_a);
        w_xs     = w_swap ? w_sb : w_sa;
        w_ex     = w_swap ? w_eb : w_ea;
        w_ey     = w_swap ? w_ea : w_eb;
        w_xm     = w_swap ? w_mb : w_ma;
        w_ym     = w_swap ? w_ma : w_mb;
        w_y_zero = w_swap ? w_a_zero : w_b_zero;
        w_d      = 32'(w_ex) - 32'(w_ey);
        w_sh     = (w_d > 32'(MAN_W + 3)) ? 32'(MAN_W + 3) : w_d;
        w_yfull  = w_y_zero ? '0 : {1'b1, w_ym, 3'b000};
        w_ysh    = w_yfull >> w_sh;
        w_ystk   = |(w_yfull & ~({MW{1'b1}} << w_sh));
        w_my     = {w_ysh[MW-1:1], w_ysh[0] | w_ystk};

        w_spec     = 1'b1;
        w_spec_flg = 4'b0000;
        w_spec_res = '0;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb)))
            w_spec_res = QNAN;
        else if (w_a_inf)
            w_spec_res = {w_sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (w_b_inf)
            w_spec_res = {w_sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (w_a_zero && w_b_zero) begin
            w_spec_res = {w_sa & w_sb, {(W-1){1'b0}}};
            w_spec_flg = 4'b0010;
        end else
            w_spec = 1'b0;
    end

    // ---------------- NORM: single-cycle leading-zero count
    logic [LW-1:0]        w_lzc;
    logic                 w_found;
    logic                 w_carry;
    logic signed [XW-1:0] w_nexp;
    logic [MW-1:0]        w_nman;
    logic                 w_uflow;

    always_comb begin
        w_lzc   = '0;
        w_found = 1'b0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (!w_found && r_sum[i]) begin
                w_lzc   = LW'(MW - 1 - i);
                w_found = 1'b1;
            end
        end
        w_carry = r_sum[SW-1];
        w_nexp  = w_carry ? (r_exp + XONE) : (r_exp - XW'(w_lzc));
        w_nman  = w_carry ? {r_sum[SW-1:2], |r_sum[1:0]} : (r_sum[MW-1:0] << w_lzc);
        w_uflow = w_nexp[XW-1] || (w_nexp == '0);
    end

    // ---------------- ROUND: nearest-even on G/R/S, renormalise on carry
    logic                 w_up, w_inx;
    logic [KW-1:0]        w_rnd;
    logic signed [XW-1:0] w_rexp;
    logic [MAN_W-1:0]     w_rman;

    always_comb begin
        w_up   = r_nman[2] & (r_nman[1] | r_nman[0] | r_nman[3]);
        w_inx  = |r_nman[2:0];
        w_rnd  = {1'b0, r_nman[MW-1:3]} + KW'(w_up);
        w_rexp = w_rnd[KW-1] ? (r_exp + XONE) : r_exp;
        w_rman = w_rnd[KW-1] ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            flags      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_spec     <= 1'b0;
            r_spec_res <= '0;
            r_spec_flg <= '0;
            r_sign     <= 1'b0;
            r_sub      <= 1'b0;
            r_exp      <= '0;
            r_mx       <= '0;
            r_my       <= '0;
            r_sum      <= '0;
            r_nman     <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_a     <= a;
                    r_b     <= {b[W-1] ^ op_sub, b[W-2:0]};
                    busy    <= 1'b1;
                    r_state <= S_ALIGN;
                end
                S_ALIGN: begin
                    r_spec     <= w_spec;
                    r_spec_res <= w_spec_res;
                    r_spec_flg <= w_spec_flg;
                    r_sign     <= w_xs;
                    r_sub      <= w_sa ^ w_sb;
                    r_exp      <= XW'(w_ex);
                    r_mx       <= {1'b1, w_xm, 3'b000};
                    r_my       <= w_my;
                    r_state    <= S_ADD;
                end
                S_ADD: begin
                    r_sum   <= r_sub ? ({1'b0, r_mx} - {1'b0, r_my}) : ({1'b0, r_mx} + {1'b0, r_my});
                    r_state <= S_NORM;
                end
                S_NORM: begin
                    // Exact cancellation and underflow become forced results here
                    if (!r_spec) begin
                        if (r_sum == '0) begin
                            r_spec     <= 1'b1;
                            r_spec_res <= '0;
                            r_spec_flg <= 4'b0010;
                        end else if (w_uflow) begin
                            r_spec     <= 1'b1;
                            r_spec_res <= {r_sign, {(W-1){1'b0}}};
                            r_spec_flg <= 4'b0111;
                        end
                    end
                    r_nman  <= w_nman;
                    r_exp   <= w_nexp;
                    r_state <= S_ROUND;
                end
                S_ROUND: begin
                    if (r_spec) begin
                        result <= r_spec_res;
                        flags  <= r_spec_flg;
                    end else if (w_rexp >= EMAX) begin
                        result <= {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        flags  <= 4'b1001;
                    end else begin
                        result <= {r_sign, w_rexp[EXP_W-1:0], w_rman};
                        flags  <= {3'b000, w_inx};
                    end
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fp_addsub_param.sv
// Bench for fp_addsub_param: directed vector tables, handshake corner sequences and
// random operands against a real-arithmetic reference, in single and half precision.
module tb_fp_addsub_param;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        s_start, s_sub, s_busy, s_done;
    logic [31:0] s_a, s_b, s_res;
    logic [3:0]  s_flg;
    logic        h_start, h_sub, h_busy, h_done;
    logic [15:0] h_a, h_b, h_res;
    logic [3:0]  h_flg;

    fp_addsub_param u_dut (
        .clk(clk), .rst(rst), .start(s_start), .op_sub(s_sub), .a(s_a), .b(s_b),
        .busy(s_busy), .done(s_done), .result(s_res), .flags(s_flg)
    );
    fp_addsub_param #(.EXP_W(5), .MAN_W(10)) u_dut_h (
        .clk(clk), .rst(rst), .start(h_start), .op_sub(h_sub), .a(h_a), .b(h_b),
        .busy(h_busy), .done(h_done), .result(h_res), .flags(h_flg)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference: exact sum in double precision, then rounded to the target format
    function automatic real to_real(input logic [63:0] x, input int ew, input int mw);
        logic [63:0] e, m, mm, d;
        longint      ed;
        e  = (x >> mw) & ((64'd1 << ew) - 64'd1);
        m  = x & ((64'd1 << mw) - 64'd1);
        ed = longint'(e) - longint'((1 << (ew - 1)) - 1) + 64'sd1023;
        mm = m << (52 - mw);
        d  = {x[ew+mw], ed[10:0], mm[51:0]};
        return $bitstoreal(d);
    endfunction

    function automatic void from_real(input real r, input int ew, input int mw,
                                      output logic [63:0] res, output logic [3:0] fl);
        logic [63:0] bits, m, keep, rem, half, sgn;
        longint      e;
        int          sh;
        bits = $realtobits(r);
        sgn  = {63'd0, bits[63]} << (ew + mw);
        if (r == 0.0) begin
            res = 64'd0;
            fl  = 4'b0010;
            return;
        end
        e    = longint'({53'd0, bits[62:52]}) - 64'sd1023 + longint'((1 << (ew - 1)) - 1);
        m    = {12'd0, bits[51:0]};
        sh   = 52 - mw;
        keep = m >> sh;
        rem  = m & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (e <= 0) begin
            res = sgn;
            fl  = 4'b0111;
            return;
        end
        if (rem > half || (rem == half && keep[0])) keep = keep + 64'd1;
        if (keep == (64'd1 << mw)) begin
            keep = 64'd0;
            e    = e + 1;
        end
        if (e >= longint'((1 << ew) - 1)) begin
            res = sgn | (((64'd1 << ew) - 64'd1) << mw);
            fl  = 4'b1001;
        end else begin
            res = sgn | (64'(e) << mw) | keep;
            fl  = {3'b000, rem != 64'd0};
        end
    endfunction

    function automatic void model(input logic [63:0] xa, input logic [63:0] xb, input logic sub,
                                  input int ew, input int mw,
                                  output logic [63:0] res, output logic [3:0] fl);
        real ra, rb;
        ra = to_real(xa, ew, mw);
        rb = to_real(xb, ew, mw);
        from_real(sub ? ra - rb : ra + rb, ew, mw, res, fl);
    endfunction

    task automatic run_s(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                         output logic [31:0] ores, output logic [3:0] ofl, output int olat);
        @(negedge clk);
        s_start = 1'b1; s_a = ia; s_b = ib; s_sub = isub;
        @(negedge clk);
        s_start = 1'b0; s_a = $urandom; s_b = $urandom; s_sub = 1'($urandom);
        olat = 0;
        while (!s_done && olat < 20) begin
            @(negedge clk);
            olat++;
        end
        ores = s_res;
        ofl  = s_flg;
    endtask

    task automatic run_h(input logic [15:0] ia, input logic [15:0] ib, input logic isub,
                         output logic [15:0] ores, output logic [3:0] ofl, output int olat);
        @(negedge clk);
        h_start = 1'b1; h_a = ia; h_b = ib; h_sub = isub;
        @(negedge clk);
        h_start = 1'b0; h_a = 16'($urandom); h_b = 16'($urandom); h_sub = 1'($urandom);
        olat = 0;
        while (!h_done && olat < 20) begin
            @(negedge clk);
            olat++;
        end
        ores = h_res;
        ofl  = h_flg;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] r;
        logic [3:0]  f;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tv[17];
        vec_t        th[6];
        logic [31:0] res;
        logic [15:0] hres;
        logic [3:0]  fl;
        logic [63:0] mres;
        logic [3:0]  mfl;
        logic [31:0] ra, rb, got;
        logic        rs;
        int          lat, ea, eb, ndone;

        tv[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000};
        tv[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0010};
        tv[2]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001};
        tv[3]  = '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001};
        tv[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b1001};
        tv[5]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b0000};
        tv[6]  = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0111};
        tv[7]  = '{32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000};
        tv[8]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0010};
        tv[9]  = '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0010};
        tv[10] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000};
        tv[11] = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000};
        tv[12] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000};
        tv[13] = '{32'h3F800000, 32'h34000000, 1'b0, 32'h3F800001, 4'b0000};
        tv[14] = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001};
        tv[15] = '{32'hBF800000, 32'h3F000000, 1'b0, 32'hBF000000, 4'b0000};
        tv[16] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 4'b0010};

        th[0] = '{32'h3C00, 32'h4000, 1'b0, 32'h4200, 4'b0000};
        th[1] = '{32'h7BFF, 32'h7BFF, 1'b0, 32'h7C00, 4'b1001};
        th[2] = '{32'h7C00, 32'h7C00, 1'b1, 32'h7E00, 4'b0000};
        th[3] = '{32'h3C00, 32'h3C00, 1'b1, 32'h0000, 4'b0010};
        th[4] = '{32'h0401, 32'h0400, 1'b1, 32'h0000, 4'b0111};
        th[5] = '{32'h3C00, 32'h1000, 1'b0, 32'h3C00, 4'b0001};

        rst = 1'b1;
        s_start = 1'b0; s_sub = 1'b0; s_a = '0; s_b = '0;
        h_start = 1'b0; h_sub = 1'b0; h_a = '0; h_b = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(s_busy), 64'd0);
        check("reset done", 64'(s_done), 64'd0);
        check("reset result", 64'(s_res), 64'd0);
        check("reset flags", 64'(s_flg), 64'd0);
        check("reset half result", 64'(h_res), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            run_s(tv[i].a, tv[i].b, tv[i].sub, res, fl, lat);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'd4);
            check($sformatf("vec%0d result", i), 64'(res), 64'(tv[i].r));
            check($sformatf("vec%0d flags", i), 64'(fl), 64'(tv[i].f));
            @(negedge clk);
            check($sformatf("vec%0d done width", i), 64'(s_done), 64'd0);
        end

        for (int i = 0; i < 6; i++) begin
            run_h(tv[0].a[15:0] ^ tv[0].a[15:0] ^ th[i].a[15:0], th[i].b[15:0], th[i].sub, hres, fl, lat);
            check($sformatf("half%0d latency", i), 64'(lat), 64'd4);
            check($sformatf("half%0d result", i), 64'(hres), 64'(th[i].r));
            check($sformatf("half%0d flags", i), 64'(fl), 64'(th[i].f));
        end

        // start pulsed again while busy must be ignored
        @(negedge clk);
        s_start = 1'b1; s_a = 32'h3F800000; s_b = 32'h40000000; s_sub = 1'b0;
        @(negedge clk);
        s_start = 1'b0;
        check("busy after start", 64'(s_busy), 64'd1);
        @(negedge clk);
        s_start = 1'b1; s_a = 32'h7F800000; s_b = 32'h3F800000;
        @(negedge clk);
        s_start = 1'b0;
        ndone = 0; got = '0;
        for (int k = 0; k < 14; k++) begin
            if (s_done) begin
                ndone++;
                got = s_res;
            end
            @(negedge clk);
        end
        check("busy-start done count", 64'(ndone), 64'd1);
        check("busy-start result", 64'(got), 64'h40400000);

        // reset while in ADD aborts the operation
        @(negedge clk);
        s_start = 1'b1; s_a = 32'h40400000; s_b = 32'h3F800000; s_sub = 1'b0;
        @(negedge clk);
        s_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort busy", 64'(s_busy), 64'd0);
        check("abort done", 64'(s_done), 64'd0);
        check("abort result", 64'(s_res), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            if (s_done) ndone++;
            @(negedge clk);
        end
        check("abort no done", 64'(ndone), 64'd0);
        run_s(32'h40400000, 32'h3F800000, 1'b0, res, fl, lat);
        check("after abort result", 64'(res), 64'h40800000);
        check("after abort flags", 64'(fl), 64'd0);

        // random single precision, exponent gap kept small enough for an exact double sum
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 7) == 0)
                ea = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : int'($urandom_range(250, 254));
            else
                ea = int'($urandom_range(1, 254));
            eb = ea + int'($urandom_range(0, 56)) - 28;
            if (eb < 1) eb = 1;
            if (eb > 254) eb = 254;
            ra = {1'($urandom), 8'(ea), 23'($urandom)};
            rb = {1'($urandom), 8'(eb), 23'($urandom)};
            rs = 1'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                rb = ra ^ 32'h1;
                rs = 1'b1;
            end
            model(64'(ra), 64'(rb), rs, 8, 23, mres, mfl);
            run_s(ra, rb, rs, res, fl, lat);
            check($sformatf("rand %h %s %h result", ra, rs ? "-" : "+", rb), 64'(res), mres);
            check($sformatf("rand %h %s %h flags", ra, rs ? "-" : "+", rb), 64'(fl), 64'(mfl));
        end

        for (int i = 0; i < 100; i++) begin
            ra = {16'd0, 1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
            rb = {16'd0, 1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
            rs = 1'($urandom);
            model(64'(ra), 64'(rb), rs, 5, 10, mres, mfl);
            run_h(ra[15:0], rb[15:0], rs, hres, fl, lat);
            check($sformatf("rand half %h %s %h result", ra[15:0], rs ? "-" : "+", rb[15:0]), 64'(hres), mres);
            check($sformatf("rand half %h %s %h flags", ra[15:0], rs ? "-" : "+", rb[15:0]), 64'(fl), 64'(mfl));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
